// File: rtl/regfile_pkg.sv
// Shared definitions for the two-read/one-write pipelined register file.
// Default geometry and the soft-clear sequencer state encoding live here.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clear_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: selects zero / bypassed write data / array entry,
// then registers it with a matching valid flag (fixed one-cycle latency).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] mem [2**ADDR_W],
  input  logic              wr_accept,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic              zero_hit;
  logic              bypass_hit;
  logic [DATA_W-1:0] rd_sel;

  // wr_accept is already low while clearing, so no bypass can happen then.
  always_comb begin
    zero_hit   = ZERO_REG && (raddr == '0);
    bypass_hit = wr_accept && (raddr == waddr) && !zero_hit;
    rd_sel     = mem[raddr];
    if (zero_hit) begin
      rd_sel = '0;
    end else if (bypass_hit) begin
      rd_sel = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= rd_sel;
      end
    end
  end

endmodule

// File: rtl/pipelined_regfile_2r1w.sv
// Register file with one write port, two registered read ports with write-first
// bypass, optional hard-wired zero entry and a one-entry-per-cycle soft clear.
//
// Handshake: a read is accepted on any edge with reK=1 and answered one cycle
// later with rvalidK=1; there is no back-pressure. Writes are accepted when
// we=1 and busy=0; busy=1 means the soft clear owns the array.
module pipelined_regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re0,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  input  logic              clear_req,
  output logic              busy
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  // Sequencer state and clear index travel together so a checker can bind
  // to a single signal.
  typedef struct packed {
    clear_state_e      state;
    logic [ADDR_W-1:0] idx;
  } clear_ctrl_t;

  clear_ctrl_t       ctrl_q;
  clear_ctrl_t       ctrl_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_accept;

  assign busy      = (ctrl_q.state == ST_CLEAR);
  assign wr_accept = we && !busy && !(ZERO_REG && (waddr == '0));

  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q.state)
      ST_IDLE: begin
        if (clear_req) begin
          ctrl_d.state = ST_CLEAR;
          ctrl_d.idx   = '0;
        end
      end
      ST_CLEAR: begin
        if (ctrl_q.idx == LAST_IDX) begin
          ctrl_d.state = ST_IDLE;
          ctrl_d.idx   = '0;
        end else begin
          ctrl_d.idx = ctrl_q.idx + 1'b1;
        end
      end
      default: begin
        ctrl_d.state = ST_IDLE;
        ctrl_d.idx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q.state <= ST_IDLE;
      ctrl_q.idx   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (busy) begin
      mem[ctrl_q.idx] <= '0;
    end else if (wr_accept) begin
      mem[waddr] <= wdata;
    end
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rd0 (
    .clk      (clk),
    .reset    (reset),
    .re       (re0),
    .raddr    (raddr0),
    .mem      (mem),
    .wr_accept(wr_accept),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata0),
    .rvalid   (rvalid0)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_rd1 (
    .clk      (clk),
    .reset    (reset),
    .re       (re1),
    .raddr    (raddr1),
    .mem      (mem),
    .wr_accept(wr_accept),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata1),
    .rvalid   (rvalid1)
  );

endmodule
